// File: rtl/mult_pkg.sv
// Shared width helpers for the pipelined multiplier; every stage record is
// {valid, a_ext, b, signed, tag, acc}, laid out MSB first in that order.
package mult_pkg;

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

  // Packed width of one stage record, used for stage-to-stage ports.
  function automatic int stage_w(input int width, input int tag_w);
    return 1 + prod_w(width) + width + 1 + tag_w + prod_w(width);
  endfunction

endpackage

// File: rtl/mult_pp_stage.sv
// One pipeline stage: registers the stage record and accumulates row ROW.
// The top row is subtracted in signed mode (two's-complement weight of b's MSB).
module mult_pp_stage
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  parameter int ROW   = 1
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            en,
  input  logic [stage_w(WIDTH,TAG_W)-1:0] d,
  output logic [stage_w(WIDTH,TAG_W)-1:0] q
);
  localparam int PW = prod_w(WIDTH);

  typedef struct packed {
    logic             valid;
    logic [PW-1:0]    a_ext;
    logic [WIDTH-1:0] b;
    logic             sgn;
    logic [TAG_W-1:0] tag;
    logic [PW-1:0]    acc;
  } stage_t;

  stage_t        di, qr;
  logic [PW-1:0] row;

  assign di = d;
  assign q  = qr;

  always_comb row = di.b[ROW] ? (di.a_ext << ROW) : '0;

  // Payload only loads with a valid entry so bubbles leave the last result in place.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      qr <= '0;
    end else if (en) begin
      qr.valid <= di.valid;
      if (di.valid) begin
        qr.a_ext <= di.a_ext;
        qr.b     <= di.b;
        qr.sgn   <= di.sgn;
        qr.tag   <= di.tag;
        qr.acc   <= (di.sgn && ROW == WIDTH - 1) ? di.acc - row : di.acc + row;
      end
    end
  end

endmodule

// File: rtl/pipe_mult.sv
// Fully pipelined WIDTH x WIDTH multiplier, one partial-product row per stage,
// with per-entry signed/unsigned mode, a carried tag and whole-pipe backpressure.
module pipe_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     in_signed,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [prod_w(WIDTH)-1:0] out_product,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     busy
);
  localparam int PW = prod_w(WIDTH);

  typedef struct packed {
    logic             valid;
    logic [PW-1:0]    a_ext;
    logic [WIDTH-1:0] b;
    logic             sgn;
    logic [TAG_W-1:0] tag;
    logic [PW-1:0]    acc;
  } stage_t;

  stage_t        s0;
  stage_t        st [WIDTH];
  logic [PW-1:0] a_ext;

  // The whole pipe freezes only when the last stage holds an unaccepted result.
  assign out_valid   = st[WIDTH-1].valid;
  assign in_ready    = !out_valid || out_ready;
  assign out_product = st[WIDTH-1].acc;
  assign out_tag     = st[WIDTH-1].tag;

  always_comb a_ext = in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s0 <= '0;
    end else if (in_ready) begin
      s0.valid <= in_valid;
      if (in_valid) begin
        s0.a_ext <= a_ext;
        s0.b     <= in_b;
        s0.sgn   <= in_signed;
        s0.tag   <= in_tag;
        s0.acc   <= in_b[0] ? a_ext : '0;
      end
    end
  end

  assign st[0] = s0;

  for (genvar i = 1; i < WIDTH; i++) begin : g_stage
    mult_pp_stage #(
      .WIDTH(WIDTH),
      .TAG_W(TAG_W),
      .ROW  (i)
    ) u_stage (
      .clock  (clock),
      .reset_n(reset_n),
      .en     (in_ready),
      .d      (st[i-1]),
      .q      (st[i])
    );
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < WIDTH; i++) busy = busy | st[i].valid;
  end

endmodule

// File: tb/tb_pipe_mult.sv
// Directed bench for pipe_mult: a WIDTH=4 instance for latency, signed,
// backpressure and reset cases, and a WIDTH=8 instance for a mixed-mode sweep.
module tb_pipe_mult;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic       p4_iv, p4_ir, p4_sg, p4_ov, p4_or, p4_busy;
  logic [3:0] p4_a, p4_b, p4_itag, p4_otag;
  logic [7:0] p4_prod;

  logic        p8_iv, p8_ir, p8_sg, p8_ov, p8_or, p8_busy;
  logic [7:0]  p8_a, p8_b;
  logic [3:0]  p8_itag, p8_otag;
  logic [15:0] p8_prod;

  pipe_mult #(.WIDTH(4), .TAG_W(4)) u4 (
    .clock(clock), .reset_n(reset_n), .in_valid(p4_iv), .in_ready(p4_ir),
    .in_a(p4_a), .in_b(p4_b), .in_signed(p4_sg), .in_tag(p4_itag),
    .out_valid(p4_ov), .out_ready(p4_or), .out_product(p4_prod),
    .out_tag(p4_otag), .busy(p4_busy)
  );

  pipe_mult #(.WIDTH(8), .TAG_W(4)) u8 (
    .clock(clock), .reset_n(reset_n), .in_valid(p8_iv), .in_ready(p8_ir),
    .in_a(p8_a), .in_b(p8_b), .in_signed(p8_sg), .in_tag(p8_itag),
    .out_valid(p8_ov), .out_ready(p8_or), .out_product(p8_prod),
    .out_tag(p8_otag), .busy(p8_busy)
  );

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [15:0] p;
    logic [3:0]  t;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", nm, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv4(input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic s, input logic [3:0] t);
    p4_iv = v; p4_a = a; p4_b = b; p4_sg = s; p4_itag = t;
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    longint p;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'(a) * longint'(b);
    return p[15:0];
  endfunction

  logic [7:0]  bp_exp [6] = '{8'd2, 8'd6, 8'd12, 8'd20, 8'd30, 8'd42};
  logic [7:0]  sw_da  [4] = '{8'h80, 8'hFF, 8'hFF, 8'h80};
  logic [7:0]  sw_db  [4] = '{8'h80, 8'hFF, 8'hFF, 8'h7F};
  logic        sw_ds  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [15:0] sw_dp  [4] = '{16'h4000, 16'hFE01, 16'h0001, 16'hC080};

  initial begin
    exp_t q[$];
    exp_t e;
    int ni, no, stn;
    bit started;

    drv4(1'b0, 4'd0, 4'd0, 1'b0, 4'd0);
    p4_or = 1'b1;
    p8_iv = 1'b0; p8_a = '0; p8_b = '0; p8_sg = 1'b0; p8_itag = '0; p8_or = 1'b1;

    // Reset state
    #12;
    chk("rst_ov4", 32'(p4_ov), 32'd0);
    chk("rst_busy4", 32'(p4_busy), 32'd0);
    chk("rst_prod4", 32'(p4_prod), 32'd0);
    chk("rst_tag4", 32'(p4_otag), 32'd0);
    chk("rst_ov8", 32'(p8_ov), 32'd0);
    chk("rst_prod8", 32'(p8_prod), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(p4_ir), 32'd1);

    // Unsigned 15*15, latency WIDTH edges
    drv4(1'b1, 4'd15, 4'd15, 1'b0, 4'd3);
    tick();                       // edge 0
    p4_iv = 1'b0;
    tick(); tick();               // edges 1,2
    chk("u_early_ov", 32'(p4_ov), 32'd0);
    tick();                       // edge 3
    chk("u_ov", 32'(p4_ov), 32'd1);
    chk("u_prod", 32'(p4_prod), 32'hE1);
    chk("u_tag", 32'(p4_otag), 32'd3);
    tick();                       // edge 4
    chk("u_ov_drop", 32'(p4_ov), 32'd0);
    chk("u_prod_hold", 32'(p4_prod), 32'hE1);

    // Signed back-to-back
    drv4(1'b1, 4'h8, 4'h8, 1'b1, 4'd1); tick();
    drv4(1'b1, 4'h8, 4'h7, 1'b1, 4'd2); tick();
    drv4(1'b1, 4'h7, 4'hF, 1'b1, 4'd3); tick();
    p4_iv = 1'b0;
    tick();
    chk("s0_ov", 32'(p4_ov), 32'd1);
    chk("s0_prod", 32'(p4_prod), 32'h40);
    chk("s0_tag", 32'(p4_otag), 32'd1);
    tick();
    chk("s1_prod", 32'(p4_prod), 32'hC8);
    chk("s1_tag", 32'(p4_otag), 32'd2);
    tick();
    chk("s2_prod", 32'(p4_prod), 32'hF9);
    chk("s2_tag", 32'(p4_otag), 32'd3);
    tick();
    chk("s_ov_drop", 32'(p4_ov), 32'd0);

    // Backpressure: 3 stall cycles once the first result shows
    ni = 0; no = 0; stn = 0; started = 1'b0;
    for (int c = 0; c < 40 && no < 6; c++) begin
      drv4(ni < 6, 4'(ni + 1), 4'(ni + 2), 1'b0, 4'(ni));
      if (p4_ov) started = 1'b1;
      p4_or = !(started && stn < 3);
      if (!p4_or) stn++;
      #1;
      if (!p4_or) chk("bp_in_ready", 32'(p4_ir), 32'd0);
      if (p4_ov) begin
        if (no < 6) begin
          chk("bp_prod", 32'(p4_prod), 32'(bp_exp[no]));
          chk("bp_tag", 32'(p4_otag), 32'(no));
        end else begin
          chk("bp_extra", 32'(p4_ov), 32'd0);
        end
      end
      if (p4_ov && p4_or) no++;
      if (p4_iv && p4_ir) ni++;
      tick();
    end
    chk("bp_count", 32'(no), 32'd6);
    chk("bp_stalls", 32'(stn), 32'd3);
    p4_iv = 1'b0; p4_or = 1'b1;

    // Asynchronous reset with three entries in flight
    drv4(1'b1, 4'd3, 4'd5, 1'b0, 4'd9); tick();
    drv4(1'b1, 4'd2, 4'd2, 1'b1, 4'd10); tick();
    drv4(1'b1, 4'd7, 4'd7, 1'b0, 4'd11); tick();
    p4_iv = 1'b0;
    chk("rm_busy_pre", 32'(p4_busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rm_ov", 32'(p4_ov), 32'd0);
    chk("rm_busy", 32'(p4_busy), 32'd0);
    chk("rm_prod", 32'(p4_prod), 32'd0);
    chk("rm_tag", 32'(p4_otag), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("rm_stale", 32'(p4_ov), 32'd0);
    end

    // Mixed-mode sweep on WIDTH=8 with random out_ready
    ni = 0; no = 0;
    for (int c = 0; c < 20000 && no < 1000; c++) begin
      if (ni < 4) begin
        p8_iv = 1'b1; p8_a = sw_da[ni]; p8_b = sw_db[ni]; p8_sg = sw_ds[ni];
      end else if (ni < 1000) begin
        p8_iv = ($urandom_range(3) != 0);
        p8_a = 8'($urandom); p8_b = 8'($urandom); p8_sg = 1'($urandom);
      end else begin
        p8_iv = 1'b0;
      end
      p8_itag = 4'(ni);
      p8_or = ($urandom_range(3) != 0);
      #1;
      if (p8_ov && !p8_or) chk("sw_in_ready", 32'(p8_ir), 32'd0);
      if (p8_ov && p8_or) begin
        if (q.size() == 0) begin
          chk("sw_extra", 32'(p8_ov), 32'd0);
        end else begin
          e = q.pop_front();
          chk("sw_prod", 32'(p8_prod), 32'(e.p));
          chk("sw_tag", 32'(p8_otag), 32'(e.t));
        end
        no++;
      end
      if (p8_iv && p8_ir) begin
        q.push_back('{p: (ni < 4) ? sw_dp[ni] : ref_mul(p8_a, p8_b, p8_sg), t: p8_itag});
        ni++;
      end
      tick();
    end
    p8_iv = 1'b0;
    chk("sw_count", 32'(no), 32'd1000);
    chk("sw_busy_end", 32'(p8_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
